// File: rtl/answer_entry.sv
// Player answer producer: synchronizes and debounces the punch button, then packs punched digits.
// Optional undo digit (toggle 4'hF) is enabled by defining ANSWER_UNDO_EN.
module answer_entry #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DIGITS     = 7
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             punch_raw,
    input  logic [3:0]                       toggle_raw,
    input  logic [3:0]                       level_num,
    input  logic                             arm,
    input  logic                             logout,
    input  logic                             answer_ack,
    output logic                             punch_pulse,
    output logic [3:0]                       seg_in_ans,
    output logic [4*DIGITS-1:0]              answer_word,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic                             answer_valid,
    output logic                             busy
);
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FULL
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_p_s1, r_p_s2;
    logic [3:0]          r_t_s1, r_t_s2;
    logic [15:0]         r_deb_cnt;
    logic                r_stable;
    logic [CW-1:0]       r_n;
    logic [CW-1:0]       w_n_clamp, w_n_nxt, w_cnt_nxt, w_cnt_inc;
    logic [4*DIGITS-1:0] w_word_nxt;
    logic                w_valid_nxt;
    logic                w_deb_flip, w_rise, w_undo;

    assign w_deb_flip = (r_p_s2 != r_stable) && (r_deb_cnt == DEB_LAST);
    assign w_rise     = w_deb_flip && r_p_s2;
    assign w_cnt_inc  = CW'(digit_count + 1'b1);
    assign busy       = (r_state == S_CAPTURE);

`ifdef ANSWER_UNDO_EN
    assign w_undo = (seg_in_ans == 4'hF);
`else
    assign w_undo = 1'b0;
`endif

    always_comb begin
        w_n_clamp = CW'(level_num);
        if (level_num == 4'd0)
            w_n_clamp = CW'(1);
        else if (32'(level_num) > DIGITS)
            w_n_clamp = CW'(DIGITS);
    end

    // Synchronizers and debouncer; logout leaves the debouncer alone so a held button cannot re-pulse
    always_ff @(posedge clock) begin
        if (rst) begin
            r_p_s1      <= 1'b0;
            r_p_s2      <= 1'b0;
            r_t_s1      <= '0;
            r_t_s2      <= '0;
            r_deb_cnt   <= '0;
            r_stable    <= 1'b0;
            punch_pulse <= 1'b0;
            seg_in_ans  <= '0;
        end else begin
            r_p_s1 <= punch_raw;
            r_p_s2 <= r_p_s1;
            r_t_s1 <= toggle_raw;
            r_t_s2 <= r_t_s1;
            if (r_p_s2 == r_stable) begin
                r_deb_cnt <= '0;
            end else if (w_deb_flip) begin
                r_stable  <= r_p_s2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 16'd1;
            end
            if (logout) begin
                punch_pulse <= 1'b0;
                seg_in_ans  <= '0;
            end else begin
                punch_pulse <= w_rise;
                if (w_rise)
                    seg_in_ans <= r_t_s2;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = answer_word;
        w_cnt_nxt   = digit_count;
        w_valid_nxt = answer_valid;
        w_n_nxt     = r_n;
        if (logout) begin
            w_state_nxt = S_IDLE;
            w_word_nxt  = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else if (arm) begin
            w_state_nxt = S_CAPTURE;
            w_word_nxt  = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_n_nxt     = w_n_clamp;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    if (punch_pulse) begin
                        if (w_undo) begin
                            if (digit_count != '0) begin
                                w_cnt_nxt = CW'(digit_count - 1'b1);
                                for (int unsigned i = 0; i < DIGITS; i++)
                                    if (i == 32'(w_cnt_nxt))
                                        w_word_nxt[4*i +: 4] = 4'h0;
                            end
                        end else begin
                            for (int unsigned i = 0; i < DIGITS; i++)
                                if (i == 32'(digit_count))
                                    w_word_nxt[4*i +: 4] = seg_in_ans;
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc == r_n) begin
                                w_state_nxt = S_FULL;
                                w_valid_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_FULL: begin
                    if (answer_ack) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            answer_word  <= '0;
            digit_count  <= '0;
            answer_valid <= 1'b0;
            r_n          <= CW'(1);
        end else begin
            answer_word  <= w_word_nxt;
            digit_count  <= w_cnt_nxt;
            answer_valid <= w_valid_nxt;
            r_n          <= w_n_nxt;
        end
    end

endmodule

// File: tb/tb_answer_entry.sv
// Directed self-checking bench for answer_entry with DEB_CYCLES=4, DIGITS=7.
module tb_answer_entry;
    logic        clock = 1'b0;
    logic        rst, punch_raw, arm, logout, answer_ack;
    logic [3:0]  toggle_raw, level_num;
    logic        punch_pulse, answer_valid, busy;
    logic [3:0]  seg_in_ans;
    logic [27:0] answer_word;
    logic [2:0]  digit_count;

    int n_total = 0;
    int n_pass  = 0;

    answer_entry #(.DEB_CYCLES(4), .DIGITS(7)) dut (
        .clock(clock), .rst(rst), .punch_raw(punch_raw), .toggle_raw(toggle_raw),
        .level_num(level_num), .arm(arm), .logout(logout), .answer_ack(answer_ack),
        .punch_pulse(punch_pulse), .seg_in_ans(seg_in_ans), .answer_word(answer_word),
        .digit_count(digit_count), .answer_valid(answer_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Settle the button low, press with digit v, return right after the edge that sets punch_pulse
    task automatic press(input logic [3:0] v);
        bit got;
        got = 1'b0;
        punch_raw = 1'b0;
        repeat (8) tick();
        toggle_raw = v;
        punch_raw  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (punch_pulse) got = 1'b1;
        end
        punch_raw = 1'b0;
        check("press_seen", 32'(got), 32'd1);
    endtask

    task automatic strobe_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; punch_raw = 1'b0; toggle_raw = 4'h0; level_num = 4'd0;
        arm = 1'b0; logout = 1'b0; answer_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_pulse", 32'(punch_pulse), 0);
        check("rst_seg", 32'(seg_in_ans), 0);
        check("rst_word", 32'(answer_word), 0);
        check("rst_count", 32'(digit_count), 0);
        check("rst_valid", 32'(answer_valid), 0);
        check("rst_busy", 32'(busy), 0);

        // Debounce latency: raw first sampled at edge k, pulse from edge k+5
        toggle_raw = 4'h3;
        punch_raw  = 1'b1;
        repeat (5) tick();
        check("lat_early", 32'(punch_pulse), 0);
        tick();
        check("lat_pulse", 32'(punch_pulse), 1);
        check("lat_seg", 32'(seg_in_ans), 32'h3);
        tick();
        check("lat_one_cycle", 32'(punch_pulse), 0);
        punch_raw = 1'b0;
        seen = 1'b0;
        repeat (12) begin tick(); if (punch_pulse) seen = 1'b1; end
        check("release_no_pulse", 32'(seen), 0);

        // Bounce filter: three 3-cycle highs never reach the threshold
        rst = 1'b1; repeat (2) tick(); rst = 1'b0;
        toggle_raw = 4'h9;
        seen = 1'b0;
        repeat (3) begin
            punch_raw = 1'b1;
            repeat (3) begin tick(); if (punch_pulse) seen = 1'b1; end
            punch_raw = 1'b0;
            repeat (3) begin tick(); if (punch_pulse) seen = 1'b1; end
        end
        repeat (6) begin tick(); if (punch_pulse) seen = 1'b1; end
        check("bounce_no_pulse", 32'(seen), 0);
        check("bounce_seg", 32'(seg_in_ans), 0);

        // Full capture at level 3
        level_num = 4'd3;
        strobe_arm();
        check("arm_busy", 32'(busy), 1);
        check("arm_count", 32'(digit_count), 0);
        press(4'h5); tick();
        press(4'hA); tick();
        press(4'h2);
        check("valid_before_third", 32'(answer_valid), 0);
        tick();
        check("valid_third", 32'(answer_valid), 1);
        check("full_word", 32'(answer_word), 32'h00002A5);
        check("full_count", 32'(digit_count), 3);
        check("full_busy", 32'(busy), 0);
        seen = 1'b0;
        repeat (20) begin tick(); if (!answer_valid || answer_word !== 28'h00002A5) seen = 1'b1; end
        check("valid_hold", 32'(seen), 0);
        answer_ack = 1'b1; tick(); answer_ack = 1'b0;
        check("ack_valid", 32'(answer_valid), 0);
        check("ack_word", 32'(answer_word), 32'h00002A5);
        check("ack_count", 32'(digit_count), 3);

        // Level 0 clamps to one digit; later level change is ignored
        level_num = 4'd0;
        strobe_arm();
        level_num = 4'd5;
        press(4'h9); tick();
        check("lvl0_valid", 32'(answer_valid), 1);
        check("lvl0_word", 32'(answer_word), 32'h9);
        check("lvl0_count", 32'(digit_count), 1);
        answer_ack = 1'b1; tick(); answer_ack = 1'b0;

        // Level 9 clamps to seven digits; an eighth punch leaves the word alone
        level_num = 4'd9;
        strobe_arm();
        for (int d = 1; d <= 7; d++) begin
            if (d == 7) check("lvl9_not_yet", 32'(answer_valid), 0);
            press(4'(d)); tick();
        end
        check("lvl9_valid", 32'(answer_valid), 1);
        check("lvl9_word", 32'(answer_word), 32'h7654321);
        check("lvl9_count", 32'(digit_count), 7);
        press(4'h8); tick();
        check("over_word", 32'(answer_word), 32'h7654321);
        check("over_count", 32'(digit_count), 7);
        check("over_seg", 32'(seg_in_ans), 32'h8);
        check("over_valid", 32'(answer_valid), 1);

        // Logout mid-capture clears everything
        level_num = 4'd3;
        strobe_arm();
        press(4'h1); tick();
        press(4'h2); tick();
        check("pre_logout_count", 32'(digit_count), 2);
        logout = 1'b1; tick(); logout = 1'b0;
        check("logout_word", 32'(answer_word), 0);
        check("logout_count", 32'(digit_count), 0);
        check("logout_valid", 32'(answer_valid), 0);
        check("logout_seg", 32'(seg_in_ans), 0);
        check("logout_busy", 32'(busy), 0);
        check("logout_pulse", 32'(punch_pulse), 0);

        // Arm coincident with a pulse discards that punch
        strobe_arm();
        press(4'h4); tick();
        check("pre_rearm_count", 32'(digit_count), 1);
        press(4'h6);
        arm = 1'b1; tick(); arm = 1'b0;
        check("rearm_count", 32'(digit_count), 0);
        check("rearm_word", 32'(answer_word), 0);
        check("rearm_busy", 32'(busy), 1);

`ifndef ANSWER_UNDO_EN
        // Without undo, 4'hF is stored as an ordinary digit
        press(4'h7); tick();
        press(4'hF); tick();
        press(4'h4); tick();
        check("f_digit_word", 32'(answer_word), 32'h00004F7);
        check("f_digit_valid", 32'(answer_valid), 1);
`else
        press(4'h7); tick();
        press(4'hF); tick();
        check("undo_count", 32'(digit_count), 0);
        check("undo_word", 32'(answer_word), 0);
        check("undo_busy", 32'(busy), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
